// File: rtl/if_stage_sramlike.sv
// Instruction-fetch stage driving an SRAM-like req/addr_ok/data_ok port, with an instruction queue to ID.
// Optional macro IF_ADEF_CHECK_EN: misaligned fetch_pc yields one ADEF-tagged nop instead of a request.
module if_stage_sramlike #(
  parameter logic [31:0] RESET_PC   = 32'h1c000000,
  parameter int          IBUF_DEPTH = 4,
  parameter int          MAX_OUTST  = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        id_allow_in,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        excp_flush,
  input  logic        ertn_flush,
  input  logic [31:0] flush_target,
  output logic        inst_req,
  output logic        inst_wr,
  output logic [1:0]  inst_size,
  output logic [31:0] inst_addr,
  output logic [31:0] inst_wdata,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic        if_to_id_valid,
  output logic [31:0] if_to_id_pc,
  output logic [31:0] if_to_id_inst,
  output logic        if_to_id_excp
);
  localparam int QW = $clog2(IBUF_DEPTH);
  localparam int CW = $clog2(IBUF_DEPTH + 1);
  localparam int PW = $clog2(MAX_OUTST);
  localparam int OW = $clog2(MAX_OUTST + 1);

  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic          held_q, held_d, held_stale_q, held_stale_d;
  logic [31:0]   held_addr_q, held_addr_d;
  logic [OW-1:0] outst_q, outst_d, discard_q, discard_d;
  logic [31:0]   pend_pc_q [MAX_OUTST];
  logic [31:0]   pend_pc_d [MAX_OUTST];
  logic [PW-1:0] pend_wr_q, pend_wr_d, pend_rd_q, pend_rd_d;
  logic [31:0]   ibuf_pc_q [IBUF_DEPTH];
  logic [31:0]   ibuf_pc_d [IBUF_DEPTH];
  logic [31:0]   ibuf_inst_q [IBUF_DEPTH];
  logic [31:0]   ibuf_inst_d [IBUF_DEPTH];
  logic [QW-1:0] q_head_q, q_head_d, q_tail_q, q_tail_d;
  logic [CW-1:0] q_count_q, q_count_d;
`ifdef IF_ADEF_CHECK_EN
  logic          ibuf_excp_q [IBUF_DEPTH];
  logic          ibuf_excp_d [IBUF_DEPTH];
  logic          adef_stall_q, adef_stall_d;
`endif

  logic        redirect, space_ok, fresh_ok, adef_push, acc, ret, stale_acc, push, pop;
  logic [31:0] redirect_target;

  assign inst_wr        = 1'b0;
  assign inst_size      = 2'd2;
  assign inst_wdata     = 32'h0;
  assign if_to_id_valid = (q_count_q != '0);
  assign if_to_id_pc    = ibuf_pc_q[q_head_q];
  assign if_to_id_inst  = ibuf_inst_q[q_head_q];
`ifdef IF_ADEF_CHECK_EN
  assign if_to_id_excp  = ibuf_excp_q[q_head_q];
`else
  assign if_to_id_excp  = 1'b0;
`endif

  always_comb begin
    redirect        = excp_flush | ertn_flush | br_taken;
    redirect_target = (excp_flush | ertn_flush) ? flush_target : br_target;
    space_ok        = (32'(outst_q) < 32'(MAX_OUTST)) &&
                      ((32'(q_count_q) + 32'(outst_q)) < 32'(IBUF_DEPTH));
`ifdef IF_ADEF_CHECK_EN
    fresh_ok  = space_ok && (fetch_pc_q[1:0] == 2'b00) && !adef_stall_q;
    adef_push = !held_q && (fetch_pc_q[1:0] != 2'b00) && !adef_stall_q &&
                (outst_q == '0) && (discard_q == '0) && (32'(q_count_q) < 32'(IBUF_DEPTH));
`else
    fresh_ok  = space_ok;
    adef_push = 1'b0;
`endif
    // A raised request is held with its original address until accepted.
    inst_req  = resetn && (held_q || fresh_ok);
    inst_addr = held_q ? held_addr_q : fetch_pc_q;
    acc       = inst_req && inst_addr_ok;
    ret       = inst_data_ok && (outst_q != '0);
    stale_acc = acc && held_q && held_stale_q;

    held_d       = inst_req && !inst_addr_ok;
    held_addr_d  = inst_addr;
    held_stale_d = (held_q && held_stale_q) || redirect;

    fetch_pc_d = fetch_pc_q;
    if (redirect)
      fetch_pc_d = redirect_target;
    else if (acc && !stale_acc)
      fetch_pc_d = fetch_pc_q + 32'd4;

    outst_d = outst_q;
    if (acc && !ret)
      outst_d = outst_q + OW'(1);
    else if (ret && !acc)
      outst_d = outst_q - OW'(1);

    // After a redirect every response still in flight belongs to the old stream.
    discard_d = discard_q;
    if (redirect) begin
      discard_d = outst_d;
    end else begin
      if (ret && (discard_q != '0))
        discard_d = discard_d - OW'(1);
      if (stale_acc)
        discard_d = discard_d + OW'(1);
    end

    pend_pc_d = pend_pc_q;
    pend_wr_d = pend_wr_q;
    pend_rd_d = pend_rd_q;
    if (acc) begin
      pend_pc_d[pend_wr_q] = inst_addr;
      pend_wr_d            = pend_wr_q + PW'(1);
    end
    if (ret)
      pend_rd_d = pend_rd_q + PW'(1);

    push        = !redirect && ((ret && (discard_q == '0)) || adef_push);
    pop         = if_to_id_valid && id_allow_in;
    ibuf_pc_d   = ibuf_pc_q;
    ibuf_inst_d = ibuf_inst_q;
    q_head_d    = q_head_q;
    q_tail_d    = q_tail_q;
    q_count_d   = q_count_q;
`ifdef IF_ADEF_CHECK_EN
    ibuf_excp_d  = ibuf_excp_q;
    adef_stall_d = redirect ? 1'b0 : (adef_stall_q || adef_push);
`endif
    if (redirect) begin
      q_head_d  = '0;
      q_tail_d  = '0;
      q_count_d = '0;
    end else begin
      if (push) begin
        ibuf_pc_d[q_tail_q]   = adef_push ? fetch_pc_q : pend_pc_q[pend_rd_q];
        ibuf_inst_d[q_tail_q] = adef_push ? 32'h03400000 : inst_rdata;
`ifdef IF_ADEF_CHECK_EN
        ibuf_excp_d[q_tail_q] = adef_push;
`endif
        q_tail_d = q_tail_q + QW'(1);
      end
      if (pop)
        q_head_d = q_head_q + QW'(1);
      if (push && !pop)
        q_count_d = q_count_q + CW'(1);
      else if (pop && !push)
        q_count_d = q_count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      fetch_pc_q   <= RESET_PC;
      held_q       <= 1'b0;
      held_stale_q <= 1'b0;
      held_addr_q  <= RESET_PC;
      outst_q      <= '0;
      discard_q    <= '0;
      pend_wr_q    <= '0;
      pend_rd_q    <= '0;
      q_head_q     <= '0;
      q_tail_q     <= '0;
      q_count_q    <= '0;
`ifdef IF_ADEF_CHECK_EN
      adef_stall_q <= 1'b0;
`endif
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      held_q       <= held_d;
      held_stale_q <= held_stale_d;
      held_addr_q  <= held_addr_d;
      outst_q      <= outst_d;
      discard_q    <= discard_d;
      pend_wr_q    <= pend_wr_d;
      pend_rd_q    <= pend_rd_d;
      q_head_q     <= q_head_d;
      q_tail_q     <= q_tail_d;
      q_count_q    <= q_count_d;
`ifdef IF_ADEF_CHECK_EN
      adef_stall_q <= adef_stall_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    pend_pc_q   <= pend_pc_d;
    ibuf_pc_q   <= ibuf_pc_d;
    ibuf_inst_q <= ibuf_inst_d;
`ifdef IF_ADEF_CHECK_EN
    ibuf_excp_q <= ibuf_excp_d;
`endif
  end

endmodule
